key_unlock_ctrl: RTL
====================

KEY_UNLOCK_CTRL -- requirements
Module: key_unlock_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter MAX_FAIL SHALL default to 3 and set the number of failed key checks that trigger lockout; the legal range is 1..7.
REQ-003 Parameters TEST_A, TEST_B and TEST_SUM SHALL default to 4'h3, 4'h5 and 5'h08; they define the golden check vector.
REQ-004 Parameter TIMEOUT SHALL default to 16 and set the LOAD idle limit in cycles (see REQ-021).
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- key_bit  in  1  serial key bit, MSB first
- key_valid  in  1  key_bit qualifier
- relock  in  1  discard the key and return to IDLE
- A_in, B_in  in  4  operands from the requester
- op_valid  in  1  operand request
- op_ready  out  1  operand accept
- res_ready  out-side input, in  1  result consumer ready
- SUM_out  out  5  registered result
- sum_valid  out  1  result valid
- key_out  out  4  key to the locked adder
- A_out, B_out  out  4  adder operands
- SUM_in  in  5  combinational adder result
- unlocked  out  1  high in UNLOCKED
- lockout  out  1  high in LOCKOUT
- fail_cnt  out  3  failed-check count

Function
REQ-006 The FSM SHALL have five states: IDLE, LOAD, CHECK, UNLOCKED and LOCKOUT.
REQ-007 In IDLE, key_valid SHALL capture key_bit into the key shift register, set the bit count to 1, and move the FSM to LOAD.
REQ-008 In LOAD, each key_valid SHALL shift in key_bit; on the 4th bit the FSM SHALL move to CHECK on the next cycle.
REQ-009 CHECK SHALL last exactly one cycle and drive key_out=shift register, A_out=TEST_A and B_out=TEST_B.
REQ-010 In CHECK, the block SHALL compare SUM_in with TEST_SUM in the same cycle:
- on a match: go to UNLOCKED and clear fail_cnt;
- on a mismatch: increment fail_cnt, then go to LOCKOUT if fail_cnt equals MAX_FAIL, otherwise to IDLE.
REQ-011 In UNLOCKED, key_out SHALL hold the verified key.
REQ-012 In every state other than CHECK and UNLOCKED, key_out, A_out and B_out SHALL be 0.
REQ-013 In UNLOCKED, op_ready SHALL equal (!sum_valid || res_ready) && !relock; op_ready SHALL be 0 in all other states.
REQ-014 When an operand is accepted (op_valid && op_ready):
- A_out=A_in and B_out=B_in combinationally;
- on the next edge, SUM_out=SUM_in and sum_valid=1 (latency 1 cycle).
REQ-015 sum_valid SHALL clear on res_ready unless a new operand is accepted in the same cycle; SUM_out SHALL stay stable while sum_valid && !res_ready.
REQ-016 relock in UNLOCKED SHALL take priority over an operand: the block SHALL clear the key register, clear sum_valid, and go to IDLE.
REQ-017 key_valid SHALL be ignored in CHECK, UNLOCKED and LOCKOUT; relock SHALL be ignored outside UNLOCKED.
REQ-018 LOCKOUT SHALL be absorbing: only rst exits it, and all requests are ignored.
REQ-019 unlocked and lockout SHALL be pure decodes of the state register.

Reset
REQ-020 rst SHALL take priority over all other inputs and force:
- state=IDLE, with key register, bit count, fail_cnt, SUM_out and sum_valid all 0;
- all outputs 0 from the next cycle, including mid-LOAD, mid-CHECK and in LOCKOUT.

Configuration
REQ-021 With macro KEY_LOAD_TIMEOUT_EN defined, TIMEOUT consecutive LOAD cycles without key_valid SHALL abort to IDLE and count as one failure, following the lockout rule of REQ-010. Without the macro, LOAD SHALL wait indefinitely and the timeout counter SHALL not exist.

Verification
REQ-022 After rst, the bench SHALL shift key bits 1,1,0,1: unlocked=1 two cycles after the 4th bit; operands A=4'h9, B=4'h7 -> SUM_out=5'h10 with sum_valid one cycle later.
REQ-023 The bench SHALL apply key 4'h0 three times: fail_cnt steps 1, 2, 3, then lockout=1; op_ready stays 0 and further key_valid is ignored until rst.
REQ-024 The bench SHALL apply a wrong key twice, then 4'hD: the block reaches UNLOCKED and fail_cnt returns to 0.
REQ-025 In UNLOCKED with res_ready=0 after one result: sum_valid=1, op_ready=0 and SUM_out is stable; raising res_ready releases one result per cycle.
REQ-026 The bench SHALL assert relock together with op_valid: the operand is not accepted, and the next cycle shows unlocked=0, key_out=0 and sum_valid=0.
REQ-027 With KEY_LOAD_TIMEOUT_EN defined, 2 key bits followed by 16 idle cycles -> IDLE with fail_cnt=1; without the macro, the FSM stays in LOAD.

Source files
------------

// File: rtl/key_unlock_ctrl_if.sv
// Operand/result handshake bus between a requester and key_unlock_ctrl.
// master = requester side, slave = key_unlock_ctrl side.
interface key_unlock_ctrl_if;
   logic [3:0] A_in;
   logic [3:0] B_in;
   logic       op_valid;
   logic       op_ready;
   logic       res_ready;
   logic [4:0] SUM_out;
   logic       sum_valid;

   modport master (
      output A_in, B_in, op_valid, res_ready,
      input  op_ready, SUM_out, sum_valid
   );

   modport slave (
      input  A_in, B_in, op_valid, res_ready,
      output op_ready, SUM_out, sum_valid
   );
endinterface

// File: rtl/key_unlock_ctrl.sv
// Key-unlock controller for a locked adder: serial key load, one-cycle golden check, lockout.
// Optional macro KEY_LOAD_TIMEOUT_EN aborts a stalled LOAD after TIMEOUT idle cycles.
module key_unlock_ctrl #(
   parameter int         MAX_FAIL = 3,
   parameter logic [3:0] TEST_A   = 4'h3,
   parameter logic [3:0] TEST_B   = 4'h5,
   parameter logic [4:0] TEST_SUM = 5'h08,
   parameter int         TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_bit,
   input  logic             key_valid,
   input  logic             relock,
   key_unlock_ctrl_if.slave op_bus,
   output logic [3:0]       key_out,
   output logic [3:0]       A_out,
   output logic [3:0]       B_out,
   input  logic [4:0]       SUM_in,
   output logic             unlocked,
   output logic             lockout,
   output logic [2:0]       fail_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_UNLOCKED,
      ST_LOCKOUT
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] key_reg, key_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [2:0] fail_cnt_reg, fail_cnt_next;
   logic [4:0] sum_reg, sum_next;
   logic       sum_valid_reg, sum_valid_next;

   logic [3:0] key_shift;
   logic [2:0] fail_cnt_inc;
   logic       check_pass;
   logic       timeout_hit;
   logic       fail_event;
   logic       op_ready_int;
   logic       accept;

   if (MAX_FAIL < 1 || MAX_FAIL > 7 || TIMEOUT < 1) begin : g_bad_cfg
      $error("key_unlock_ctrl: MAX_FAIL must be 1..7 and TIMEOUT at least 1");
   end

   // MSB-first shift: new bit enters at bit 0, older bits move up.
   genvar gi;
   assign key_shift[0] = key_bit;
   for (gi = 1; gi < 4; gi++) begin : g_key_shift
      assign key_shift[gi] = key_reg[gi-1];
   end

   assign check_pass   = (SUM_in == TEST_SUM);
   assign fail_cnt_inc = fail_cnt_reg + 3'd1;
   assign fail_event   = ((state_reg == ST_CHECK) && !check_pass) || timeout_hit;

   // relock masks op_ready so a simultaneous operand is never accepted.
   assign op_ready_int = (state_reg == ST_UNLOCKED)
                         && (!sum_valid_reg || op_bus.res_ready) && !relock;
   assign accept       = op_bus.op_valid && op_ready_int;

`ifdef KEY_LOAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

   always_comb begin
      idle_cnt_next = '0;
      timeout_hit   = 1'b0;
      if ((state_reg == ST_LOAD) && !key_valid) begin
         if (idle_cnt_reg == TW'(TIMEOUT - 1))
            timeout_hit = 1'b1;
         else
            idle_cnt_next = idle_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         idle_cnt_reg <= '0;
      else
         idle_cnt_reg <= idle_cnt_next;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (key_valid) state_next = ST_LOAD;
         ST_LOAD:     if (key_valid && (bit_cnt_reg == 3'd3)) state_next = ST_CHECK;
         ST_CHECK:    state_next = check_pass ? ST_UNLOCKED : ST_IDLE;
         ST_UNLOCKED: if (relock) state_next = ST_IDLE;
         ST_LOCKOUT:  state_next = ST_LOCKOUT;
         default:     state_next = ST_IDLE;
      endcase
      // Failed check and LOAD timeout share one lockout rule.
      if (fail_event)
         state_next = (fail_cnt_inc == 3'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
   end

   always_comb begin
      key_next       = key_reg;
      bit_cnt_next   = bit_cnt_reg;
      fail_cnt_next  = fail_cnt_reg;
      sum_next       = sum_reg;
      sum_valid_next = sum_valid_reg;
      case (state_reg)
         ST_IDLE: begin
            if (key_valid) begin
               key_next     = {3'b000, key_bit};
               bit_cnt_next = 3'd1;
            end
         end
         ST_LOAD: begin
            if (key_valid) begin
               key_next     = key_shift;
               bit_cnt_next = bit_cnt_reg + 3'd1;
            end
         end
         ST_CHECK: begin
            bit_cnt_next = '0;
            if (check_pass)
               fail_cnt_next = '0;
         end
         ST_UNLOCKED: begin
            if (relock) begin
               key_next       = '0;
               sum_valid_next = 1'b0;
            end else if (accept) begin
               sum_next       = SUM_in;
               sum_valid_next = 1'b1;
            end else if (op_bus.res_ready) begin
               sum_valid_next = 1'b0;
            end
         end
         default: ;
      endcase
      if (fail_event) begin
         fail_cnt_next = fail_cnt_inc;
         key_next      = '0;
         bit_cnt_next  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_reg       <= '0;
         bit_cnt_reg   <= '0;
         fail_cnt_reg  <= '0;
         sum_reg       <= '0;
         sum_valid_reg <= 1'b0;
      end else begin
         key_reg       <= key_next;
         bit_cnt_reg   <= bit_cnt_next;
         fail_cnt_reg  <= fail_cnt_next;
         sum_reg       <= sum_next;
         sum_valid_reg <= sum_valid_next;
      end
   end

   always_comb begin
      key_out = '0;
      A_out   = '0;
      B_out   = '0;
      case (state_reg)
         ST_CHECK: begin
            key_out = key_reg;
            A_out   = TEST_A;
            B_out   = TEST_B;
         end
         ST_UNLOCKED: begin
            key_out = key_reg;
            if (accept) begin
               A_out = op_bus.A_in;
               B_out = op_bus.B_in;
            end
         end
         default: ;
      endcase
   end

   assign op_bus.op_ready  = op_ready_int;
   assign op_bus.SUM_out   = sum_reg;
   assign op_bus.sum_valid = sum_valid_reg;
   assign unlocked         = (state_reg == ST_UNLOCKED);
   assign lockout          = (state_reg == ST_LOCKOUT);
   assign fail_cnt         = fail_cnt_reg;

endmodule
